// File: rtl/risc_pkg.sv
// Shared definitions for the multi_cycle core, its word memory and the boot loader.
package risc_pkg;

    localparam int WORD_W = 16;
    localparam int unsigned MEM_WORDS_DEFAULT = 256;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DAT_HI,
        DAT_LO,
        CHK,
        RUN,
        ERR
    } loader_state_e;

endpackage

// File: rtl/prog_loader.sv
// Boot loader: assembles a byte stream into big-endian words, writes them to memory,
// verifies an XOR checksum and only then releases the core from reset.
module prog_loader
    import risc_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR = 16'h0000,
    parameter int unsigned       MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              err
);

    loader_state_e     state_q;
    logic [15:0]       word_cnt_q;
    logic [15:0]       idx_q;
    logic [7:0]        xor_q;
    logic [7:0]        hi_q;
    logic              mem_we_q;
    logic [WORD_W-1:0] mem_addr_q;
    logic [WORD_W-1:0] mem_wdata_q;

    logic              accept;
    logic [15:0]       hdr_count;
    logic [15:0]       idx_next;

    // Ready depends only on the registered state, never on in_valid.
    assign in_ready  = (state_q != RUN) && (state_q != ERR);
    assign accept    = in_valid && in_ready;
    assign hdr_count = {word_cnt_q[15:8], in_data};
    assign idx_next  = idx_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HDR_HI;
            word_cnt_q  <= '0;
            idx_q       <= '0;
            xor_q       <= '0;
            hi_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (accept) begin
                case (state_q)
                    HDR_HI: begin
                        word_cnt_q[15:8] <= in_data;
                        state_q          <= HDR_LO;
                    end
                    HDR_LO: begin
                        word_cnt_q <= hdr_count;
                        if (hdr_count == 16'd0) begin
                            state_q <= CHK;
                        end else if ({16'd0, hdr_count} > MEM_WORDS) begin
                            state_q <= ERR;
                        end else begin
                            state_q <= DAT_HI;
                        end
                    end
                    DAT_HI: begin
                        hi_q    <= in_data;
                        xor_q   <= xor_q ^ in_data;
                        state_q <= DAT_LO;
                    end
                    DAT_LO: begin
                        xor_q       <= xor_q ^ in_data;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= BASE_ADDR + idx_q;
                        mem_wdata_q <= {hi_q, in_data};
                        idx_q       <= idx_next;
                        state_q     <= (idx_next == word_cnt_q) ? CHK : DAT_HI;
                    end
                    CHK: begin
                        state_q <= (in_data == xor_q) ? RUN : ERR;
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_reset = (state_q != RUN);
    assign done       = (state_q == RUN);
    assign err        = (state_q == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: streams hand-built images and checks writes and status.
module tb_prog_loader;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        core_reset;
    logic        done;
    logic        err;

    int checks;
    int failures;

    logic [7:0]  txq[$];
    logic [15:0] wAddr[$];
    logic [15:0] wData[$];

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_reset(core_reset),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every cycle with mem_we high is logged, so a stretched strobe shows up as an extra write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wAddr.push_back(mem_addr);
            wData.push_back(mem_wdata);
        end
    end

    task automatic doReset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wAddr.delete();
        wData.delete();
    endtask

    task automatic sendStream(input int gap);
        int n;
        foreach (txq[i]) begin
            in_valid = 1'b1;
            in_data  = txq[i];
            n = 0;
            while (in_ready !== 1'b1 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL ready_timeout byte %0d: in_ready=%b required 1", i, in_ready);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                checks++;
                if (in_ready !== 1'b1 && i != txq.size() - 1) begin
                    failures++;
                    $display("[TB] FAIL ready_in_gap: in_ready=%b required 1", in_ready);
                end
                @(posedge clk);
                #1;
            end
        end
        txq.delete();
    endtask

    task automatic checkStatus(input string name, input logic expDone, input logic expErr,
                               input logic expCoreRst, input logic expReady);
        checks++;
        if (done !== expDone || err !== expErr || core_reset !== expCoreRst || in_ready !== expReady) begin
            failures++;
            $display("[TB] FAIL %s: done=%b err=%b core_reset=%b in_ready=%b required %b %b %b %b",
                     name, done, err, core_reset, in_ready, expDone, expErr, expCoreRst, expReady);
        end
    endtask

    task automatic checkWrites(input string name, input int expN,
                               input logic [15:0] a0, input logic [15:0] d0,
                               input logic [15:0] a1, input logic [15:0] d1,
                               input logic [15:0] a2, input logic [15:0] d2,
                               input logic [15:0] a3, input logic [15:0] d3);
        logic [15:0] ea[4];
        logic [15:0] ed[4];
        ea = '{a0, a1, a2, a3};
        ed = '{d0, d1, d2, d3};
        checks++;
        if (wAddr.size() != expN) begin
            failures++;
            $display("[TB] FAIL %s_count: writes=%0d required %0d", name, wAddr.size(), expN);
        end else begin
            for (int i = 0; i < expN; i++) begin
                checks++;
                if (wAddr[i] !== ea[i] || wData[i] !== ed[i]) begin
                    failures++;
                    $display("[TB] FAIL %s_word%0d: addr=%h data=%h required addr=%h data=%h",
                             name, i, wAddr[i], wData[i], ea[i], ed[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_mem: we=%b addr=%h data=%h required 0 0000 0000", mem_we, mem_addr, mem_wdata);
        end
        checkStatus("reset_status", 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_load4();
        doReset();
        txq = '{8'h00, 8'h04, 8'h02, 8'ha0, 8'h08, 8'h48, 8'h0d, 8'hf8, 8'h0f, 8'hf8, 8'he0};
        sendStream(0);
        checkStatus("load4_done", 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkWrites("load4", 4, 16'h0000, 16'h02a0, 16'h0001, 16'h0848,
                    16'h0002, 16'h0df8, 16'h0003, 16'h0ff8);
        checkStatus("load4_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_bad_checksum();
        doReset();
        txq = '{8'h00, 8'h04, 8'h02, 8'ha0, 8'h08, 8'h48, 8'h0d, 8'hf8, 8'h0f, 8'hf8, 8'he1};
        sendStream(0);
        checkStatus("badsum_err", 1'b0, 1'b1, 1'b1, 1'b0);
        checkWrites("badsum", 4, 16'h0000, 16'h02a0, 16'h0001, 16'h0848,
                    16'h0002, 16'h0df8, 16'h0003, 16'h0ff8);
    endtask

    task automatic test_count_limits();
        doReset();
        txq = '{8'h01, 8'h00};
        sendStream(0);
        checkStatus("count256_ok", 1'b0, 1'b0, 1'b1, 1'b1);
        doReset();
        txq = '{8'h01, 8'h01};
        sendStream(0);
        checkStatus("count257_err", 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkWrites("count257", 0, '0, '0, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic test_empty();
        doReset();
        txq = '{8'h00, 8'h00, 8'h00};
        sendStream(0);
        checkStatus("empty_done", 1'b1, 1'b0, 1'b0, 1'b0);
        checkWrites("empty", 0, '0, '0, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic test_gaps();
        doReset();
        txq = '{8'h00, 8'h01, 8'ha2, 8'h81, 8'h23};
        sendStream(1);
        checkStatus("gaps_done", 1'b1, 1'b0, 1'b0, 1'b0);
        checkWrites("gaps", 1, 16'h0000, 16'ha281, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic test_reset_midstream();
        doReset();
        txq = '{8'h00, 8'h02, 8'h02};
        sendStream(0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkStatus("midrst_state", 1'b0, 1'b0, 1'b1, 1'b1);
        checkWrites("midrst_none", 0, '0, '0, '0, '0, '0, '0, '0, '0);
        txq = '{8'h00, 8'h01, 8'hb7, 8'h3c, 8'h8b};
        sendStream(0);
        checkStatus("midrst_done", 1'b1, 1'b0, 1'b0, 1'b0);
        checkWrites("midrst", 1, 16'h0000, 16'hb73c, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic test_reset_in_run();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkStatus("runrst", 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_load4();
        test_bad_checksum();
        test_count_limits();
        test_empty();
        test_gaps();
        test_reset_midstream();
        test_reset_in_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
